// File: rtl/ni_outstanding_ctrl.sv
// AW/AR issue arbiter with per-ID outstanding tracking for an AXI NI initiator.
// Define NI_OUTS_STATS_EN to add the blocked-cycle statistics counter.
module ni_outstanding_ctrl #(
   parameter int NUM_IDS     = 16,
   parameter int LOG_NUM_IDS = 4,
   parameter int MAX_OUTS    = 7,
   parameter int CNT_WD      = 3,
   parameter int TARGET_WD   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   input  logic [LOG_NUM_IDS-1:0] wr_id,
   input  logic [TARGET_WD-1:0]   wr_target,
   output logic                   wr_grant,
   input  logic                   rd_valid,
   input  logic [LOG_NUM_IDS-1:0] rd_id,
   input  logic [TARGET_WD-1:0]   rd_target,
   output logic                   rd_grant,
   input  logic                   inj_stall,
   input  logic                   wr_retire,
   input  logic [LOG_NUM_IDS-1:0] wr_retire_id,
   input  logic                   rd_retire,
   input  logic [LOG_NUM_IDS-1:0] rd_retire_id,
   output logic [NUM_IDS-1:0]     response_awaited,
   output logic                   idle,
   output logic                   err_underflow
`ifdef NI_OUTS_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [15:0]            blocked_cycles
`endif
);

   typedef logic [CNT_WD-1:0]    cnt_t;
   typedef logic [TARGET_WD-1:0] tgt_t;

   cnt_t wr_cnt_q [NUM_IDS];
   cnt_t wr_cnt_d [NUM_IDS];
   cnt_t rd_cnt_q [NUM_IDS];
   cnt_t rd_cnt_d [NUM_IDS];
   tgt_t wr_tgt_q [NUM_IDS];
   tgt_t wr_tgt_d [NUM_IDS];
   tgt_t rd_tgt_q [NUM_IDS];
   tgt_t rd_tgt_d [NUM_IDS];

   logic last_wr_q, last_wr_d;
   logic err_q, err_d;
   logic wr_elig, rd_elig;

   // A retire on an empty counter is ignored; a grant still counts.
   function automatic cnt_t cnt_nxt(cnt_t c, logic inc, logic dec);
      logic dv;
      dv = dec & (c != '0);
      unique case ({inc, dv})
         2'b10:   return c + cnt_t'(1);
         2'b01:   return c - cnt_t'(1);
         default: return c;
      endcase
   endfunction

   always_comb begin
      wr_elig = wr_valid & ~inj_stall
              & (int'(wr_cnt_q[wr_id]) < MAX_OUTS)
              & ((wr_cnt_q[wr_id] == '0)
                 | (wr_tgt_q[wr_id] == wr_target));
      rd_elig = rd_valid & ~inj_stall
              & (int'(rd_cnt_q[rd_id]) < MAX_OUTS)
              & ((rd_cnt_q[rd_id] == '0)
                 | (rd_tgt_q[rd_id] == rd_target));
      wr_grant = wr_elig & (~rd_elig | ~last_wr_q);
      rd_grant = rd_elig & (~wr_elig | last_wr_q);
   end

   always_comb begin
      last_wr_d = last_wr_q;
      if (wr_grant | rd_grant) last_wr_d = wr_grant;
      err_d = err_q
            | (wr_retire & (wr_cnt_q[wr_retire_id] == '0))
            | (rd_retire & (rd_cnt_q[rd_retire_id] == '0));
      for (int i = 0; i < NUM_IDS; i++) begin
         wr_cnt_d[i] = cnt_nxt(wr_cnt_q[i],
            wr_grant & (wr_id == LOG_NUM_IDS'(i)),
            wr_retire & (wr_retire_id == LOG_NUM_IDS'(i)));
         rd_cnt_d[i] = cnt_nxt(rd_cnt_q[i],
            rd_grant & (rd_id == LOG_NUM_IDS'(i)),
            rd_retire & (rd_retire_id == LOG_NUM_IDS'(i)));
         wr_tgt_d[i] = wr_tgt_q[i];
         rd_tgt_d[i] = rd_tgt_q[i];
         if (wr_grant && wr_id == LOG_NUM_IDS'(i))
            wr_tgt_d[i] = wr_target;
         if (rd_grant && rd_id == LOG_NUM_IDS'(i))
            rd_tgt_d[i] = rd_target;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_wr_q <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_IDS; i++) begin
            wr_cnt_q[i] <= '0;
            rd_cnt_q[i] <= '0;
            wr_tgt_q[i] <= '0;
            rd_tgt_q[i] <= '0;
         end
      end else begin
         last_wr_q <= last_wr_d;
         err_q     <= err_d;
         for (int i = 0; i < NUM_IDS; i++) begin
            wr_cnt_q[i] <= wr_cnt_d[i];
            rd_cnt_q[i] <= rd_cnt_d[i];
            wr_tgt_q[i] <= wr_tgt_d[i];
            rd_tgt_q[i] <= rd_tgt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_IDS; i++)
         response_awaited[i] = (|wr_cnt_q[i]) | (|rd_cnt_q[i]);
   end

   assign idle          = ~|response_awaited;
   assign err_underflow = err_q;

`ifdef NI_OUTS_STATS_EN
   logic [15:0] blk_q;
   logic        blk;

   assign blk = (wr_valid | rd_valid) & ~inj_stall
              & ~wr_grant & ~rd_grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         blk_q <= '0;
      else if (stats_clr)
         blk_q <= '0;
      else if (blk && blk_q != 16'hFFFF)
         blk_q <= blk_q + 16'd1;
   end

   assign blocked_cycles = blk_q;
`endif

endmodule

// File: tb/tb_ni_outstanding_ctrl.sv
// Bench for ni_outstanding_ctrl: directed vector table, stats sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_ni_outstanding_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, rd_valid, inj_stall;
   logic [3:0]  wr_id, wr_target, rd_id, rd_target;
   logic        wr_grant, rd_grant;
   logic        wr_retire, rd_retire;
   logic [3:0]  wr_retire_id, rd_retire_id;
   logic [15:0] response_awaited;
   logic        idle, err_underflow;
`ifdef NI_OUTS_STATS_EN
   logic        stats_clr;
   logic [15:0] blocked_cycles;
`endif

   always #5 clk = ~clk;

   ni_outstanding_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .wr_valid         (wr_valid),
      .wr_id            (wr_id),
      .wr_target        (wr_target),
      .wr_grant         (wr_grant),
      .rd_valid         (rd_valid),
      .rd_id            (rd_id),
      .rd_target        (rd_target),
      .rd_grant         (rd_grant),
      .inj_stall        (inj_stall),
      .wr_retire        (wr_retire),
      .wr_retire_id     (wr_retire_id),
      .rd_retire        (rd_retire),
      .rd_retire_id     (rd_retire_id),
      .response_awaited (response_awaited),
      .idle             (idle),
      .err_underflow    (err_underflow)
`ifdef NI_OUTS_STATS_EN
      ,
      .stats_clr        (stats_clr),
      .blocked_cycles   (blocked_cycles)
`endif
   );

   typedef struct {
      logic        r;
      logic        wv;
      logic [3:0]  wi, wt;
      logic        rv;
      logic [3:0]  ri, rt;
      logic        st;
      logic        wr;
      logic [3:0]  wri;
      logic        rr;
      logic [3:0]  rri;
      logic        ewg, erg;
      logic [15:0] eaw;
      logic        eer;
   } vec_t;

   vec_t tbl[$];
   int   pass_n = 0;
   int   tot_n  = 0;

   logic [3:0] mw [16][$];
   logic [3:0] mr [16][$];
   logic       m_last;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic add(input logic r, wv, input logic [3:0] wi, wt,
                      input logic rv, input logic [3:0] ri, rt,
                      input logic st, wr, input logic [3:0] wri,
                      input logic rr, input logic [3:0] rri,
                      input logic ewg, erg, input logic [15:0] eaw,
                      input logic eer);
      vec_t v;
      v.r = r; v.wv = wv; v.wi = wi; v.wt = wt;
      v.rv = rv; v.ri = ri; v.rt = rt; v.st = st;
      v.wr = wr; v.wri = wri; v.rr = rr; v.rri = rri;
      v.ewg = ewg; v.erg = erg; v.eaw = eaw; v.eer = eer;
      tbl.push_back(v);
   endtask

   task automatic drv(input vec_t v);
      rst = v.r;
      wr_valid = v.wv; wr_id = v.wi; wr_target = v.wt;
      rd_valid = v.rv; rd_id = v.ri; rd_target = v.rt;
      inj_stall = v.st;
      wr_retire = v.wr; wr_retire_id = v.wri;
      rd_retire = v.rr; rd_retire_id = v.rri;
   endtask

   function automatic bit elig_w(logic [3:0] id, logic [3:0] t);
      return mw[id].size() < 7 &&
             (mw[id].size() == 0 || mw[id][0] == t);
   endfunction

   function automatic bit elig_r(logic [3:0] id, logic [3:0] t);
      return mr[id].size() < 7 &&
             (mr[id].size() == 0 || mr[id][0] == t);
   endfunction

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit         pw, pr, stl, wrt, rrt, ew, er, gw, gr;
      logic [3:0] pwid, pwt, prid, prt, wrid, rrid;
      logic [15:0] eaw;

      rst = 1'b0;
      wr_valid = 0; wr_id = 0; wr_target = 0;
      rd_valid = 0; rd_id = 0; rd_target = 0;
      inj_stall = 0;
      wr_retire = 0; wr_retire_id = 0;
      rd_retire = 0; rd_retire_id = 0;
`ifdef NI_OUTS_STATS_EN
      stats_clr = 0;
`endif

      // single write id3: latency and retire
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      add(1, 1,3,2, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0000, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0008, 0);
      add(1, 0,0,0, 0,0,0, 0, 1,3, 0,0, 0,0, 16'h0008, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      // MAX_OUTS on id5
      for (int k = 0; k < 7; k++)
         add(1, 1,5,1, 0,0,0, 0, 0,0, 0,0, 1,0,
             (k == 0) ? 16'h0000 : 16'h0020, 0);
      add(1, 1,5,1, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0020, 0);
      add(1, 1,5,1, 0,0,0, 0, 1,5, 0,0, 0,0, 16'h0020, 0);
      add(1, 1,5,1, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0020, 0);
      for (int k = 0; k < 7; k++)
         add(1, 0,0,0, 0,0,0, 0, 1,5, 0,0, 0,0, 16'h0020, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      // same-ID ordering across targets
      add(1, 1,2,1, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0000, 0);
      add(1, 1,2,4, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0004, 0);
      add(1, 1,6,4, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0004, 0);
      add(1, 1,2,4, 0,0,0, 0, 1,2, 0,0, 0,0, 16'h0044, 0);
      add(1, 1,2,4, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0040, 0);
      add(1, 0,0,0, 0,0,0, 0, 1,2, 0,0, 0,0, 16'h0044, 0);
      add(1, 0,0,0, 0,0,0, 0, 1,6, 0,0, 0,0, 16'h0040, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      // round robin after reset, stall gap
      add(0, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 1,0, 16'h0000, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 0,1, 16'h0002, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 1,0, 16'h0002, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 0,1, 16'h0002, 0);
      for (int k = 0; k < 3; k++)
         add(1, 1,1,0, 1,1,0, 1, 0,0, 0,0, 0,0, 16'h0002, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 1,0, 16'h0002, 0);
      add(1, 1,1,0, 1,1,0, 0, 0,0, 0,0, 0,1, 16'h0002, 0);
      for (int k = 0; k < 3; k++)
         add(1, 0,0,0, 0,0,0, 0, 1,1, 1,1, 0,0, 16'h0002, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      // grant+retire same ID, underflow, reset mid-burst
      add(1, 0,0,0, 1,9,0, 0, 0,0, 0,0, 0,1, 16'h0000, 0);
      add(1, 0,0,0, 1,9,0, 0, 0,0, 1,9, 0,1, 16'h0200, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0200, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 1,0, 0,0, 16'h0200, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0200, 1);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 1,9, 0,0, 16'h0200, 1);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 1);
      add(1, 1,4,3, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0000, 1);
      add(1, 1,4,3, 0,0,0, 0, 0,0, 0,0, 1,0, 16'h0010, 1);
      add(0, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);
      add(1, 0,0,0, 0,0,0, 0, 0,0, 0,0, 0,0, 16'h0000, 0);

      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (tbl[k]) begin
         @(negedge clk);
         drv(tbl[k]);
         #4;
         chk($sformatf("v%0d grants", k), {wr_grant, rd_grant},
             {tbl[k].ewg, tbl[k].erg});
         chk($sformatf("v%0d awaited", k), response_awaited,
             tbl[k].eaw);
         chk($sformatf("v%0d idle", k), idle, tbl[k].eaw == 16'h0);
         chk($sformatf("v%0d err", k), err_underflow, tbl[k].eer);
      end

`ifdef NI_OUTS_STATS_EN
      @(negedge clk);
      wr_valid = 1; wr_id = 2; wr_target = 1; stats_clr = 1;
      #4 chk("stats first grant", wr_grant, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         stats_clr = 0; wr_target = 5;
         #4 chk("stats blocked", wr_grant, 1'b0);
      end
      @(negedge clk);
      wr_valid = 0;
      #4 chk("stats count10", blocked_cycles, 16'd10);
      @(negedge clk);
      stats_clr = 1;
      @(negedge clk);
      stats_clr = 0; wr_retire = 1; wr_retire_id = 2;
      #4 chk("stats clr", blocked_cycles, 16'd0);
      @(negedge clk);
      wr_retire = 0;
      #4 chk("stats idle", idle, 1'b1);
`endif

      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         mw[i].delete();
         mr[i].delete();
      end
      m_last = 0; pw = 0; pr = 0;
      pwid = 0; pwt = 0; prid = 0; prt = 0;
      @(negedge clk);
      rst = 1;

      repeat (2000) begin
         @(negedge clk);
         if (!pw && $urandom_range(0, 2) != 0) begin
            pw = 1;
            pwid = 4'($urandom_range(0, 3));
            pwt = 4'($urandom_range(0, 1));
         end else if (pw && $urandom_range(0, 9) == 0) pw = 0;
         if (!pr && $urandom_range(0, 2) != 0) begin
            pr = 1;
            prid = 4'($urandom_range(0, 3));
            prt = 4'($urandom_range(0, 1));
         end else if (pr && $urandom_range(0, 9) == 0) pr = 0;
         stl = ($urandom_range(0, 4) == 0);
         wrid = 4'($urandom_range(0, 3));
         rrid = 4'($urandom_range(0, 3));
         wrt = mw[wrid].size() != 0 && $urandom_range(0, 2) == 0;
         rrt = mr[rrid].size() != 0 && $urandom_range(0, 2) == 0;

         wr_valid = pw; wr_id = pwid; wr_target = pwt;
         rd_valid = pr; rd_id = prid; rd_target = prt;
         inj_stall = stl;
         wr_retire = wrt; wr_retire_id = wrid;
         rd_retire = rrt; rd_retire_id = rrid;

         ew = pw && !stl && elig_w(pwid, pwt);
         er = pr && !stl && elig_r(prid, prt);
         gw = ew && (!er || !m_last);
         gr = er && !gw;
         for (int i = 0; i < 16; i++)
            eaw[i] = mw[i].size() != 0 || mr[i].size() != 0;

         #4;
         chk("rnd grants", {wr_grant, rd_grant}, {gw, gr});
         chk("rnd awaited", response_awaited, eaw);
         chk("rnd idle", idle, eaw == 16'h0);
         chk("rnd err", err_underflow, 1'b0);

         @(posedge clk);
         if (wrt) void'(mw[wrid].pop_front());
         if (rrt) void'(mr[rrid].pop_front());
         if (gw) begin
            mw[pwid].push_back(pwt);
            m_last = 1; pw = 0;
         end
         if (gr) begin
            mr[prid].push_back(prt);
            m_last = 0; pr = 0;
         end
      end

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule

// File: doc/ni_outstanding_ctrl.md
Name: ni_outstanding_ctrl

Overview:
- Issue scheduler and outstanding-transaction tracker for an AXI NI initiator.
- Arbitrates between pending write (AW) and read (AR) transactions for the single request-flit injection path.
- Keeps per-ID, per-direction outstanding counters, refuses issue that would break AXI same-ID ordering across targets, and retires entries on response completion.
- Sits between the AXI request front-end and the packetiser/out_buffer; retire pulses come from the response path.

Parameters:
- NUM_IDS, 16, number of AXI IDs tracked.
- LOG_NUM_IDS, 4, width of ID fields.
- MAX_OUTS, 7, max outstanding transactions per ID per direction (1..2^CNT_WD-1).
- CNT_WD, 3, per-ID counter width.
- TARGET_WD, 4, width of transaction_target.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-low.
- wr_valid  in  1  write transaction pending issue.
- wr_id  in  LOG_NUM_IDS  its AXI ID.
- wr_target  in  TARGET_WD  decoded target.
- wr_grant  out  1  write issued this cycle.
- rd_valid  in  1  read transaction pending issue.
- rd_id  in  LOG_NUM_IDS  its AXI ID.
- rd_target  in  TARGET_WD  decoded target.
- rd_grant  out  1  read issued this cycle.
- inj_stall  in  1  injection path full; no grant allowed.
- wr_retire  in  1  pulse: write response fully delivered.
- wr_retire_id  in  LOG_NUM_IDS  ID of retired write.
- rd_retire  in  1  pulse: last read beat delivered.
- rd_retire_id  in  LOG_NUM_IDS  ID of retired read.
- response_awaited  out  NUM_IDS  bit i = any write or read outstanding on ID i.
- idle  out  1  no transaction outstanding on any ID.
- err_underflow  out  1  sticky: retire seen on an ID with count 0.

Behaviour:
- State per ID and direction: cnt (CNT_WD) and tgt (TARGET_WD). Arbiter state: last_wr (1 bit).
- Reset: all cnt=0, tgt=0, last_wr=0, err_underflow=0. Outputs at reset: grants 0, response_awaited=0, idle=1.
- Reset asserted mid-operation discards all tracking immediately.
- Eligibility is combinational. Write is eligible when all hold:
  - wr_valid is high.
  - inj_stall is low.
  - wr cnt[wr_id] < MAX_OUTS.
  - wr cnt[wr_id]==0, or wr tgt[wr_id]==wr_target.
- Read eligibility is identical, using rd_* signals and the read tables.
- Grant is combinational, same cycle as eligibility. At most one grant per cycle.
- Both eligible: round-robin. Grant the direction not granted last, i.e. the read if last_wr==1, otherwise the write.
- On any grant: last_wr <= (write granted).
- Requester holds valid/id/target stable until granted. Deasserting valid without a grant is legal.
- On grant: cnt[id] increments at the clock edge and tgt[id] <= target. The new value is visible next cycle (1-cycle latency).
- On retire: cnt[retire_id] decrements. If cnt is already 0: no change, err_underflow <= 1.
- Grant and retire on the same ID/direction in the same cycle: net cnt unchanged; tgt updated from the grant.
- Write and read tables are independent. Write and read retires may both occur in the same cycle.
- Counter at MAX_OUTS: eligibility false until a retire lands, so issue can resume the cycle after that retire.
- tgt is not cleared on reaching 0; it is simply ignored while cnt==0.
- response_awaited[i] = (wr cnt[i]!=0) | (rd cnt[i]!=0), registered-derived with no combinational path from inputs.
- idle = ~|response_awaited.

Optional Feature:
- Macro: NI_OUTS_STATS_EN.
- When defined, adds output blocked_cycles [15:0]. This is a saturating counter of cycles where a valid was high, inj_stall was low, and no grant was given (ordering or MAX_OUTS blocking).
  - Resets to 0.
  - Holds at 16'hFFFF once reached.
  - Add input stats_clr: synchronous clear, which has priority over increment.
- When undefined: no port, no logic; all other behaviour identical.

Test Plan:
- Reset, then wr_valid id=3 tgt=2 -> wr_grant same cycle; next cycle response_awaited=16'h0008, idle=0. wr_retire id=3 -> response_awaited=0 one cycle later.
- 7 writes id=5 tgt=1 -> all granted; 8th held with wr_grant=0. Pulse wr_retire id=5 -> 8th granted the following cycle.
- Write id=2 tgt=1 outstanding, then new write id=2 tgt=4 -> blocked. Write id=6 tgt=4 -> granted. After retire of id=2 -> blocked write granted.
- wr_valid and rd_valid held continuously, both eligible -> grants alternate W,R,W,R starting with W after reset. inj_stall=1 for 3 cycles -> no grants, alternation resumes.
- rd cnt[9]=1; rd_grant id=9 and rd_retire id=9 in the same cycle -> cnt stays 1. Then rd_retire id=0 with cnt 0 -> err_underflow=1 and stays 1 until reset. Assert rst mid-burst -> all cnt=0, idle=1.
- With NI_OUTS_STATS_EN: hold a blocked write 10 cycles -> blocked_cycles=10. Pulse stats_clr -> 0.
